// File: rtl/memory_pkg.sv
// Shared encodings for memory_arbiter: bus transfer types, transfer sizes,
// requester ids, the owner tag carried down the pipeline, and reset values.
package memory_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] SIZE_RST = SIZE_WORD;
  localparam logic [1:0] PROT_RST = 2'b10;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } tag_t;

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational grant picker. Round-robin on contention when
// MEMORY_ARBITER_RR_EN is defined, otherwise data port beats instruction port.
module memory_arbiter_select
  import memory_pkg::*;
(
  input  logic clk,
  input  logic n_reset,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

`ifdef MEMORY_ARBITER_RR_EN
  port_e r_last;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_last <= PORT_I;
    end else if (i_gnt) begin
      r_last <= PORT_I;
    end else if (d_gnt) begin
      r_last <= PORT_D;
    end
  end

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (n_reset) begin
      if (i_req && d_req) begin
        // The port that has waited longest since its last grant wins.
        d_gnt = (r_last == PORT_I);
        i_gnt = (r_last == PORT_D);
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end
`else
  logic w_unused_clk;
  assign w_unused_clk = clk;

  always_comb begin
    d_gnt = n_reset & d_req;
    i_gnt = n_reset & i_req & ~d_req;
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one pipelined memory interface between instruction and data ports.
// Arbitration policy lives in memory_arbiter_select (MEMORY_ARBITER_RR_EN).
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_prot,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_abort,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic [1:0]        d_size,
  input  logic [1:0]        d_prot,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_abort,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              write,
  output logic [1:0]        size,
  output logic [1:0]        prot,
  output logic [1:0]        trans,
  input  logic [DATA_W-1:0] rdata,
  input  logic              abort
);

  logic              w_any_gnt;
  port_e             w_win_port;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_win_write;
  logic [1:0]        w_win_size;
  logic [1:0]        w_win_prot;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_seq;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [1:0]        r_size;
  logic [1:0]        r_prot;
  logic [1:0]        r_trans;
  tag_t              r_ap_tag;
  tag_t              r_dp_tag;

  memory_arbiter_select u_select (
    .clk     (clk),
    .n_reset (n_reset),
    .i_req   (i_req),
    .d_req   (d_req),
    .i_gnt   (i_gnt),
    .d_gnt   (d_gnt)
  );

  assign w_any_gnt  = i_gnt | d_gnt;
  assign w_addr_inc = r_addr + ADDR_W'(1);

  always_comb begin
    w_win_port  = d_gnt ? PORT_D : PORT_I;
    w_win_addr  = d_gnt ? d_addr : i_addr;
    w_win_write = d_gnt & d_write;
    w_win_size  = d_gnt ? d_size : i_size;
    w_win_prot  = d_gnt ? d_prot : i_prot;
    // The address-phase tag is exactly the transfer issued last cycle.
    w_seq = r_ap_tag.vld && (r_ap_tag.port == w_win_port) &&
            (r_write == w_win_write) && (w_win_addr == w_addr_inc);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_size   <= SIZE_RST;
      r_prot   <= PROT_RST;
      r_trans  <= TRANS_IDLE;
      r_ap_tag <= '0;
      r_dp_tag <= '0;
    end else begin
      r_dp_tag <= r_ap_tag;
      r_ap_tag <= '{vld: w_any_gnt, port: w_win_port};
      if (w_any_gnt) begin
        r_addr  <= w_win_addr;
        r_write <= w_win_write;
        r_size  <= w_win_size;
        r_prot  <= w_win_prot;
        r_trans <= w_seq ? TRANS_SEQ : TRANS_NONSEQ;
        if (d_gnt) begin
          r_wdata <= d_wdata;
        end
      end else begin
        r_write <= 1'b0;
        r_trans <= TRANS_IDLE;
      end
    end
  end

  assign addr  = r_addr;
  assign wdata = r_wdata;
  assign write = r_write;
  assign size  = r_size;
  assign prot  = r_prot;
  assign trans = r_trans;

  assign i_done  = r_dp_tag.vld && (r_dp_tag.port == PORT_I);
  assign d_done  = r_dp_tag.vld && (r_dp_tag.port == PORT_D);
  assign i_rdata = i_done ? rdata : '0;
  assign d_rdata = d_done ? rdata : '0;
  assign i_abort = i_done & abort;
  assign d_abort = d_done & abort;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed sequences, an arbitration
// table, and random traffic checked against a transaction-level model.
module tb_memory_arbiter;

  localparam logic [31:0] ABORT_ADDR = 32'h0000_DEAD;

  logic        clk;
  logic        n_reset;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        d_write;
  logic [1:0]  i_size, i_prot, d_size, d_prot;
  logic        i_gnt, d_gnt, i_done, d_done, i_abort, d_abort;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] addr, wdata, rdata;
  logic        write, abort;
  logic [1:0]  size, prot, trans;

  memory_arbiter dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_prot(i_prot),
    .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata), .i_abort(i_abort),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
    .d_size(d_size), .d_prot(d_prot),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_abort(d_abort),
    .addr(addr), .wdata(wdata), .write(write), .size(size), .prot(prot),
    .trans(trans), .rdata(rdata), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: 256 words indexed by the low address byte.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (n_reset && trans != 2'b00) begin
      if (write) mem[addr[7:0]] <= wdata;
      else       rdata <= mem[addr[7:0]];
      abort <= (addr == ABORT_ADDR);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference model.
  typedef struct {
    bit          vld;
    bit          port;   // 1 = data port
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [1:0]  prot;
    bit          seq;
    logic [31:0] data;
    bit          abt;
  } xfer_t;

  xfer_t       hist[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] m_addr;
  logic [1:0]  m_size, m_prot;
  bit          m_last_d;

  logic        g_rst_n, g_ir, g_dr, g_dwr;
  logic [31:0] g_ia, g_da, g_dw;
  logic [1:0]  g_is, g_ip, g_ds, g_dp;
  logic        s_i_gnt, s_d_gnt;

  task automatic model_reset();
    xfer_t z;
    z = '{default: '0};
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_addr = '0; m_size = 2'b10; m_prot = 2'b10; m_last_d = 1'b0;
  endtask

  task automatic model_eval();
    bit ei, ed;
    xfer_t prev, old, nx;
    if (g_ir && g_dr) begin
`ifdef MEMORY_ARBITER_RR_EN
      ed = !m_last_d; ei = m_last_d;
`else
      ed = 1'b1; ei = 1'b0;
`endif
    end else begin
      ei = g_ir; ed = g_dr;
    end
    s_i_gnt = i_gnt; s_d_gnt = d_gnt;
    check("i_gnt", i_gnt, ei);
    check("d_gnt", d_gnt, ed);
    prev = hist[hist.size()-1];
    old  = hist[hist.size()-2];
    check("trans", trans, !prev.vld ? 32'd0 : (prev.seq ? 32'd3 : 32'd2));
    check("write", write, prev.vld && prev.wr);
    check("addr", addr, m_addr);
    check("size", size, m_size);
    check("prot", prot, m_prot);
    if (prev.vld && prev.wr) check("wdata", wdata, prev.wdata);
    check("i_done", i_done, old.vld && !old.port);
    check("d_done", d_done, old.vld && old.port);
    check("i_abort", i_abort, old.vld && !old.port && old.abt);
    check("d_abort", d_abort, old.vld && old.port && old.abt);
    check("i_rdata", i_rdata, (old.vld && !old.port) ? old.data : 32'd0);
    if (!(old.vld && old.port && old.wr))
      check("d_rdata", d_rdata, (old.vld && old.port) ? old.data : 32'd0);
    nx = '{default: '0};
    if (ei || ed) begin
      nx.vld   = 1'b1;
      nx.port  = ed;
      nx.addr  = ed ? g_da : g_ia;
      nx.wr    = ed && g_dwr;
      nx.wdata = g_dw;
      nx.size  = ed ? g_ds : g_is;
      nx.prot  = ed ? g_dp : g_ip;
      nx.seq   = prev.vld && (prev.port == nx.port) && (prev.wr == nx.wr) &&
                 (nx.addr == prev.addr + 32'd1);
      nx.abt   = (nx.addr == ABORT_ADDR);
      if (nx.wr) ref_mem[nx.addr] = nx.wdata;
      else nx.data = ref_mem.exists(nx.addr) ? ref_mem[nx.addr] : 32'd0;
      m_addr = nx.addr; m_size = nx.size; m_prot = nx.prot; m_last_d = ed;
    end
    hist.push_back(nx);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic cycle();
    @(negedge clk);
    n_reset = g_rst_n;
    i_req = g_ir; i_addr = g_ia; i_size = g_is; i_prot = g_ip;
    d_req = g_dr; d_addr = g_da; d_wdata = g_dw; d_write = g_dwr;
    d_size = g_ds; d_prot = g_dp;
    #1;
    if (!n_reset) begin
      check("rst_i_gnt", i_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_trans", trans, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_write", write, 0);
      check("rst_size", size, 2'b10);
      check("rst_prot", prot, 2'b10);
      check("rst_done", {i_done, d_done}, 0);
      s_i_gnt = 1'b0; s_d_gnt = 1'b0;
      model_reset();
    end else begin
      model_eval();
    end
  endtask

  task automatic idle();
    g_ir = 1'b0; g_dr = 1'b0;
  endtask

  task automatic ireq(input logic [31:0] a);
    g_ir = 1'b1; g_ia = a; g_is = 2'b10; g_ip = 2'b01;
  endtask

  task automatic dreq(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    g_dr = 1'b1; g_da = a; g_dwr = wr; g_dw = wd; g_ds = 2'b10; g_dp = 2'b11;
  endtask

  function automatic logic [31:0] pick_addr(input logic [31:0] last);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return (last == 32'hFFFF_FFFF) ? 32'h0 : ((last + 32'd1) & 32'h7F);
    if (r == 4) return 32'hFFFF_FFFF;
    return 32'($urandom_range(0, 127));
  endfunction

  typedef struct {
    logic ir, dr, ei, ed;
  } arb_vec_t;
  arb_vec_t tbl[10];

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[8'h10] = 32'hA5A5_A5A5; ref_mem[32'h10] = 32'hA5A5_A5A5;
    mem[8'h20] = 32'h1111_0020; ref_mem[32'h20] = 32'h1111_0020;
    mem[8'h21] = 32'h2222_0021; ref_mem[32'h21] = 32'h2222_0021;
    mem[8'h22] = 32'h3333_0022; ref_mem[32'h22] = 32'h3333_0022;
    rdata = '0; abort = 1'b0;
    n_reset = 1'b0;
    g_rst_n = 1'b0; g_ia = '0; g_is = '0; g_ip = '0;
    g_da = '0; g_dw = '0; g_dwr = 1'b0; g_ds = '0; g_dp = '0;
    idle();
    g_ir = 1'b1;           // gnt must stay low while in reset
    model_reset();
    cycle(); cycle();
    g_rst_n = 1'b1; idle(); cycle();

    // Single instruction read
    ireq(32'h10); cycle(); check("t1_i_gnt", i_gnt, 1);
    idle(); cycle(); check("t1_addr", addr, 32'h10); check("t1_trans", trans, 2'b10);
    cycle();
    check("t1_i_done", i_done, 1); check("t1_i_rdata", i_rdata, 32'hA5A5_A5A5);
    check("t1_d_done", d_done, 0);

    // Sequential burst on the instruction port
    ireq(32'h20); cycle();
    ireq(32'h21); cycle(); check("t2_trans0", trans, 2'b10);
    ireq(32'h22); cycle(); check("t2_trans1", trans, 2'b11);
    check("t2_rd0", i_rdata, 32'h1111_0020);
    idle(); cycle(); check("t2_trans2", trans, 2'b11); check("t2_rd1", i_rdata, 32'h2222_0021);
    cycle(); check("t2_done2", i_done, 1); check("t2_rd2", i_rdata, 32'h3333_0022);

    // Write then read back on the data port
    dreq(32'h30, 1'b1, 32'h55); cycle();
    dreq(32'h30, 1'b0, 32'h0); cycle();
    check("t3_write1", write, 1); check("t3_trans1", trans, 2'b10);
    idle(); cycle(); check("t3_write0", write, 0); check("t3_trans2", trans, 2'b10);
    cycle(); check("t3_d_done", d_done, 1); check("t3_d_rdata", d_rdata, 32'h55);

    // Address wrap still counts as sequential
    ireq(32'hFFFF_FFFF); cycle();
    ireq(32'h0); cycle();
    idle(); cycle(); check("wrap_trans", trans, 2'b11); check("wrap_addr", addr, 32'h0);
    cycle();

    // Memory abort on a data read
    dreq(ABORT_ADDR, 1'b0, 32'h0); cycle();
    idle(); cycle(); cycle();
    check("ab_d_done", d_done, 1); check("ab_d_abort", d_abort, 1);
    check("ab_i_abort", i_abort, 0);

    // Reset during the address phase drops the transfer
    dreq(32'h40, 1'b0, 32'h0); cycle(); check("rm_d_gnt", d_gnt, 1);
    idle(); g_rst_n = 1'b0; cycle();
    g_rst_n = 1'b1; cycle(); check("rm_no_done", {i_done, d_done}, 0);
    ireq(32'h10); cycle();
    idle(); cycle(); check("rm_trans", trans, 2'b10);
    cycle(); check("rm_i_done", i_done, 1); check("rm_i_rdata", i_rdata, 32'hA5A5_A5A5);

    // Arbitration table, starting with last winner = instruction port
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 1};
    tbl[2] = '{1, 0, 1, 0};
`ifdef MEMORY_ARBITER_RR_EN
    for (int k = 3; k < 9; k++) tbl[k] = '{1, 1, (k % 2 == 0), (k % 2 == 1)};
`else
    for (int k = 3; k < 9; k++) tbl[k] = '{1, 1, 0, 1};
`endif
    tbl[9] = '{0, 0, 0, 0};
    for (int k = 0; k < 10; k++) begin
      idle();
      if (tbl[k].ir) ireq(32'h50);
      if (tbl[k].dr) dreq(32'h60, 1'b0, 32'h0);
      cycle();
      check($sformatf("tbl%0d_i_gnt", k), i_gnt, tbl[k].ei);
      check($sformatf("tbl%0d_d_gnt", k), d_gnt, tbl[k].ed);
    end

    // Random traffic against the model
    idle(); cycle();
    for (int n = 0; n < 400; n++) begin
      if (g_ir && s_i_gnt) g_ir = 1'b0;
      if (g_dr && s_d_gnt) g_dr = 1'b0;
      if (g_ir && $urandom_range(0, 19) == 0) g_ir = 1'b0;
      if (g_dr && $urandom_range(0, 19) == 0) g_dr = 1'b0;
      if (!g_ir && $urandom_range(0, 2) != 0) begin
        g_ir = 1'b1; g_ia = pick_addr(g_ia);
        g_is = 2'($urandom_range(0, 2)); g_ip = 2'($urandom_range(0, 3));
      end
      if (!g_dr && $urandom_range(0, 2) != 0) begin
        g_dr = 1'b1; g_da = pick_addr(g_da); g_dwr = 1'($urandom_range(0, 1));
        g_dw = $urandom; g_ds = 2'($urandom_range(0, 2)); g_dp = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    idle(); cycle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
